// File: rtl/uart_tx_cfg_pkg.sv
// Shared definitions for the configurable UART transmitter: FSM state
// encoding, parity/stop field encodings and a data-width clamp helper.
package uart_tx_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // parity_mode encodings (11 behaves as none)
    localparam logic [1:0] PARITY_NONE = 2'b00;
    localparam logic [1:0] PARITY_EVEN = 2'b01;
    localparam logic [1:0] PARITY_ODD  = 2'b10;

    // stop_mode encodings (11 behaves as one stop bit)
    localparam logic [1:0] STOP_1   = 2'b00;
    localparam logic [1:0] STOP_1P5 = 2'b01;
    localparam logic [1:0] STOP_2   = 2'b10;

    // Out-of-range data widths fall back to the full word width.
    function automatic logic [3:0] clamp_bits(input logic [3:0] b, input int dmax);
        if (int'(b) < 5 || int'(b) > dmax)
            return 4'(dmax);
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter. Frame format (width, parity, stop
// length) and the data word are captured on the accepting edge, so the
// frame in flight is immune to later input changes. Bit timing is counted
// in oversampling ticks from the shared baud generator.
module uart_tx_cfg
    import uart_tx_cfg_pkg::*;
#(
    parameter int DBIT_MAX   = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_tick,
    input  logic [DBIT_MAX-1:0] din,
    input  logic                tx_valid,
    output logic                tx_ready,
    input  logic [3:0]          data_bits,
    input  logic [1:0]          parity_mode,
    input  logic [1:0]          stop_mode,
    output logic                tx,
    output logic                tx_done_tick,
    output logic                busy
);

    localparam int TW = $clog2(2*OVERSAMPLE);
    // Terminal counts: a bit ends on the tick where the counter hits these.
    localparam logic [TW-1:0] T_BIT  = TW'(OVERSAMPLE-1);
    localparam logic [TW-1:0] T_S1P5 = TW'(3*OVERSAMPLE/2-1);
    localparam logic [TW-1:0] T_S2   = TW'(2*OVERSAMPLE-1);

    tx_state_t           state, state_next;
    logic [TW-1:0]       tick_cnt;
    logic [3:0]          bit_cnt;
    logic [3:0]          nbits_r;
    logic [DBIT_MAX-1:0] shreg;
    logic                par_en_r, par_r;
    logic [TW-1:0]       stop_end_r;
    logic                tx_r, done_r;
    logic                tx_d, done_d;

    logic                accept;
    logic                tick_last, stop_last, data_last;
    logic [3:0]          nbits_in;
    logic                par_in;
    logic [TW-1:0]       stop_end_in;

    assign accept    = tx_valid && (state == ST_IDLE);
    assign nbits_in  = clamp_bits(data_bits, DBIT_MAX);
    assign tick_last = s_tick && (tick_cnt == T_BIT);
    assign stop_last = s_tick && (tick_cnt == stop_end_r);
    assign data_last = (bit_cnt == nbits_r - 4'd1);

    // Parity over the low nbits_in bits of the offered word; odd seeds with 1.
    always_comb begin
        par_in = (parity_mode == PARITY_ODD);
        for (int i = 0; i < DBIT_MAX; i++)
            if (i < int'(nbits_in))
                par_in = par_in ^ din[i];
    end

    // Stop-bit terminal count selected from the offered stop_mode.
    always_comb begin
        case (stop_mode)
            STOP_1P5: stop_end_in = T_S1P5;
            STOP_2:   stop_end_in = T_S2;
            default:  stop_end_in = T_BIT;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state logic; everything past IDLE advances only on tick boundaries.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (accept)    state_next = ST_START;
            ST_START:  if (tick_last) state_next = ST_DATA;
            ST_DATA:   if (tick_last && data_last)
                           state_next = par_en_r ? ST_PARITY : ST_STOP;
            ST_PARITY: if (tick_last) state_next = ST_STOP;
            ST_STOP:   if (stop_last) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Outputs: handshake decoded from state; line level and done pulse
    // computed from the upcoming state so both register on the boundary edge.
    always_comb begin
        tx_ready = (state == ST_IDLE);
        busy     = (state != ST_IDLE);
        done_d   = (state == ST_STOP) && (state_next == ST_IDLE);
        case (state_next)
            ST_START:  tx_d = 1'b0;
            // shreg shifts on this same edge when a data bit ends in DATA
            ST_DATA:   tx_d = (state == ST_DATA && tick_last) ? shreg[1] : shreg[0];
            ST_PARITY: tx_d = par_r;
            default:   tx_d = 1'b1;
        endcase
    end

    // Datapath: capture on accept, then tick counting and data shifting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            nbits_r    <= '0;
            shreg      <= '0;
            par_en_r   <= 1'b0;
            par_r      <= 1'b0;
            stop_end_r <= '0;
            tx_r       <= 1'b1;
            done_r     <= 1'b0;
        end else begin
            tx_r   <= tx_d;
            done_r <= done_d;
            if (accept) begin
                shreg      <= din;
                nbits_r    <= nbits_in;
                par_en_r   <= (parity_mode == PARITY_EVEN) || (parity_mode == PARITY_ODD);
                par_r      <= par_in;
                stop_end_r <= stop_end_in;
                tick_cnt   <= '0;
                bit_cnt    <= '0;
            end else if (s_tick && state != ST_IDLE) begin
                if (state_next != state || (state == ST_DATA && tick_last))
                    tick_cnt <= '0;
                else
                    tick_cnt <= tick_cnt + 1'b1;
                if (state == ST_DATA && tick_last) begin
                    shreg   <= shreg >> 1;
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end
        end
    end

    assign tx           = tx_r;
    assign tx_done_tick = done_r;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: directed frames from the test plan plus randomized
// frames, each compared tick-by-tick against a per-tick line-level list
// built from the frame-format rules.
module tb_uart_tx_cfg;

    localparam int DBIT_MAX = 8;
    localparam int OS       = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_tick = 1'b0;
    logic [7:0] din = '0;
    logic       tx_valid = 1'b0;
    logic [3:0] data_bits = 4'd8;
    logic [1:0] parity_mode = 2'b00;
    logic [1:0] stop_mode = 2'b00;
    logic       tx_ready, tx, tx_done_tick, busy;

    int tests = 0;
    int fails = 0;
    int ph = 0;
    logic exp_q[$];

    uart_tx_cfg #(.DBIT_MAX(DBIT_MAX), .OVERSAMPLE(OS)) dut (
        .clk(clk), .reset(reset), .s_tick(s_tick), .din(din),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .data_bits(data_bits),
        .parity_mode(parity_mode), .stop_mode(stop_mode), .tx(tx),
        .tx_done_tick(tx_done_tick), .busy(busy)
    );

    always #5 clk = ~clk;

    // Oversampling strobe: one clk high every 4, changing just after posedge.
    initial forever begin
        @(posedge clk);
        #1;
        ph = (ph + 1) % 4;
        s_tick = (ph == 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level for every tick of a frame.
    task automatic build(input logic [7:0] d, input logic [3:0] db,
                         input logic [1:0] pm, input logic [1:0] sm);
        int  nb;
        int  st;
        logic p;
        nb = (db < 5 || db > 8) ? 8 : int'(db);
        exp_q.delete();
        repeat (OS) exp_q.push_back(1'b0);
        for (int i = 0; i < nb; i++)
            repeat (OS) exp_q.push_back(d[i]);
        if (pm == 2'b01 || pm == 2'b10) begin
            p = 1'b0;
            for (int i = 0; i < nb; i++) p = p ^ d[i];
            if (pm == 2'b10) p = ~p;
            repeat (OS) exp_q.push_back(p);
        end
        st = (sm == 2'b01) ? (3*OS/2) : (sm == 2'b10) ? 2*OS : OS;
        repeat (st) exp_q.push_back(1'b1);
    endtask

    // Offer a word at a negedge, then check every tick of the frame and the
    // done pulse. hold keeps tx_valid high; scramble churns inputs mid-frame.
    task automatic frame(input logic [7:0] d, input logic [3:0] db,
                         input logic [1:0] pm, input logic [1:0] sm,
                         input bit hold, input bit scramble, input string tag);
        int n;
        chk({tag, ":ready_before"}, 32'(tx_ready), 32'd1);
        din = d; data_bits = db; parity_mode = pm; stop_mode = sm; tx_valid = 1'b1;
        build(d, db, pm, sm);
        @(posedge clk);
        @(negedge clk);
        chk({tag, ":start_tx"}, 32'(tx), 32'd0);
        chk({tag, ":start_busy"}, 32'(busy), 32'd1);
        if (!hold) tx_valid = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            n = 0;
            while (!s_tick && n < 8) begin
                @(negedge clk);
                n++;
            end
            if (!s_tick) begin
                tests++;
                fails++;
                $error("FAIL %s:tick_timeout observed=no_tick expected=tick", tag);
                break;
            end
            chk($sformatf("%s:tx[%0d]", tag, k), 32'(tx), 32'(exp_q[k]));
            chk($sformatf("%s:done_low[%0d]", tag, k), 32'(tx_done_tick), 32'd0);
            chk($sformatf("%s:ready_low[%0d]", tag, k), 32'(tx_ready), 32'd0);
            if (scramble) begin
                din = 8'($urandom);
                data_bits = 4'($urandom);
                parity_mode = 2'($urandom);
                stop_mode = 2'($urandom);
            end
            @(negedge clk);
        end
        chk({tag, ":done"}, 32'(tx_done_tick), 32'd1);
        chk({tag, ":ready_after"}, 32'(tx_ready), 32'd1);
        chk({tag, ":tx_idle"}, 32'(tx), 32'd1);
    endtask

    task automatic gap(input string tag);
        @(negedge clk);
        chk({tag, ":done_once"}, 32'(tx_done_tick), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int  cnt;
        bit  bad;
        repeat (3) @(negedge clk);
        chk("rst:tx", 32'(tx), 32'd1);
        chk("rst:ready", 32'(tx_ready), 32'd1);
        chk("rst:busy", 32'(busy), 32'd0);
        chk("rst:done", 32'(tx_done_tick), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        frame(8'hA5, 4'd8, 2'b00, 2'b00, 0, 0, "8N1");   gap("8N1");
        frame(8'hC1, 4'd7, 2'b01, 2'b00, 0, 0, "7E1");   gap("7E1");
        frame(8'h00, 4'd8, 2'b10, 2'b10, 0, 0, "8O2");   gap("8O2");
        frame(8'h1F, 4'd5, 2'b10, 2'b01, 0, 0, "5O1p5"); gap("5O1p5");

        // back-to-back with tx_valid held and config churn during frame 1
        frame(8'h55, 4'd8, 2'b00, 2'b00, 1, 1, "b2b_1");
        frame(8'h33, 4'd8, 2'b00, 2'b00, 0, 0, "b2b_2"); gap("b2b_2");

        // reset during data bit 3
        din = 8'hA5; data_bits = 4'd8; parity_mode = 2'b00; stop_mode = 2'b00;
        tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        cnt = 0;
        while (cnt < OS + 3*OS + OS/2) begin
            if (s_tick) cnt++;
            @(negedge clk);
        end
        #2 reset = 1'b1;
        #1;
        chk("midrst:tx", 32'(tx), 32'd1);
        chk("midrst:ready", 32'(tx_ready), 32'd1);
        chk("midrst:busy", 32'(busy), 32'd0);
        chk("midrst:done", 32'(tx_done_tick), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx_done_tick !== 1'b0 || tx !== 1'b1) bad = 1;
        end
        chk("midrst:quiet", 32'(bad), 32'd0);
        frame(8'h0F, 4'd8, 2'b00, 2'b00, 0, 0, "rst_fresh"); gap("rst_fresh");

        frame(8'h5A, 4'd12, 2'b11, 2'b11, 0, 0, "illegal"); gap("illegal");

        for (int r = 0; r < 8; r++) begin
            frame(8'($urandom), 4'($urandom_range(0, 15)), 2'($urandom),
                  2'($urandom), 0, r[0], $sformatf("rnd%0d", r));
            gap($sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
